sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
Arbitrates the single external async SRAM between two requesters. The display fetch port is read-only, high priority and is fed by the VGA renderer. The text port is read/write and is fed by the VT100 terminal/text-buffer writer. It sequences SRAM strobes with a fixed access window and a turnaround cycle. It sits inside the video controller, between those requesters and the top-level SRAM pins. The top level owns the inout data tristate, driven from sram_drive.

Parameters:
ADDR_WIDTH, 20, SRAM word-address width
DATA_WIDTH, 32, SRAM data width
WAIT_CYCLES, 2, cycles strobes are held per access (>=1)
STARVE_LIMIT, 8, max consecutive display grants while text_req is pending before text is forced (>=1)

Ports:
clk  in  1  system clock (100 MHz domain)
rst  in  1  synchronous active-high reset
disp_req  in  1  display read request, held until disp_ack
disp_addr  in  ADDR_WIDTH  display read address, stable while disp_req
disp_ack  out  1  one-cycle pulse: request accepted, address latched
disp_rdata  out  DATA_WIDTH  display read data
disp_rvalid  out  1  one-cycle pulse: disp_rdata valid
text_req  in  1  text request, held until text_ack
text_we  in  1  1=write, 0=read; stable while text_req
text_addr  in  ADDR_WIDTH  text address
text_wdata  in  DATA_WIDTH  text write data
text_ack  out  1  one-cycle pulse: request accepted
text_rdata  out  DATA_WIDTH  text read data, held until next text read completes
text_rvalid  out  1  one-cycle pulse: text_rdata valid (reads only)
sram_addr  out  ADDR_WIDTH  SRAM address
sram_dout  out  DATA_WIDTH  write data to pins
sram_din  in  DATA_WIDTH  read data from pins
sram_drive  out  1  tristate enable for sram_dout
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low

Behaviour:
- All outputs are registered. Reset values: ce_n/oe_n/we_n=1, drive=0, sram_addr=0, sram_dout=0, acks=0, rvalids=0, rdatas=0, starve counter=0, state IDLE.
- FSM states: IDLE -> ACCESS (WAIT_CYCLES cycles) -> RECOVER (1 cycle) -> IDLE. One access costs WAIT_CYCLES+2 cycles, i.e. 4 at the defaults.
- IDLE: samples the request inputs. The owner is chosen as follows.
  - Only one requester is pending: that requester wins.
  - Both are pending: display wins unless starve count == STARVE_LIMIT, in which case text wins.
  - Neither is pending: stay in IDLE with all strobes high.
- Grant edge: latch addr, we and wdata, then enter ACCESS.
  - The owner's ack is high during the first ACCESS cycle.
  - A requester must deassert req, or present a new transaction, in the cycle after ack. Any req still high in IDLE counts as a new request.
- ACCESS, read: ce_n=0, oe_n=0, we_n=1, drive=0. sram_din is captured on the edge ending the last ACCESS cycle. The owner's rdata updates and its rvalid pulses in the RECOVER cycle.
- ACCESS, write: ce_n=0, we_n=0, oe_n=1, drive=1, sram_dout=wdata. No rvalid is produced.
- RECOVER: ce_n=oe_n=we_n=1.
  - After a write, drive stays 1 and addr/dout are held (data hold); drive goes 0 on entry to IDLE.
  - After a read, drive stays 0.
- sram_addr is held from grant through RECOVER. Address is never changed while a strobe is low.
- Read latency: req sampled in IDLE at cycle N -> ack at N+1 -> rvalid at N+1+WAIT_CYCLES.
- Starve counter:
  - Increments on each display grant while text_req=1, saturating at STARVE_LIMIT.
  - Clears on any text grant, or in any IDLE cycle with text_req=0.
- Display port never writes. The display port has no we input.
- req dropped before its ack: not granted; no side effects.
- Reset mid-access: the next edge forces all strobes high, drive=0 and IDLE. The in-flight transaction is dropped with no ack or rvalid, and requesters reissue.
- sram_din is sampled only in the last ACCESS cycle of a read.

Test Plan:
- Single display read, addr=0x00123, SRAM model returns 0xDEADBEEF -> disp_ack at N+1; oe_n low for 2 cycles; disp_rvalid at N+3 with 0xDEADBEEF; we_n stays 1 throughout.
- Text write, addr=0x00040, data=0x0000_1F41 -> text_ack at N+1; we_n low exactly 2 cycles; drive high 3 cycles; address stable 1 cycle past we_n rising; model memory holds the value.
- Simultaneous disp_req and text_req held continuously, STARVE_LIMIT=8 -> grant order is 8 display then 1 text, repeating; one grant every 4 cycles; no rvalid on the write.
- Back-to-back text write then text read at the same addr 0x00040 -> the read returns 0x00001F41; RECOVER cycle between them has all strobes high.
- rst asserted during the 2nd ACCESS cycle of a write -> next cycle we_n=ce_n=1, drive=0; no ack or rvalid; after release, a new read completes normally.
- text_req pulsed and dropped while a display access is in flight -> never granted; starve counter clears; no text_ack.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port arbiter for the external async SRAM: high-priority read-only display
// fetch port and a read/write text port, with a fixed strobe window plus recovery.
module sram_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 20,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  disp_req,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic                  disp_ack,
  output logic [DATA_WIDTH-1:0] disp_rdata,
  output logic                  disp_rvalid,
  input  logic                  text_req,
  input  logic                  text_we,
  input  logic [ADDR_WIDTH-1:0] text_addr,
  input  logic [DATA_WIDTH-1:0] text_wdata,
  output logic                  text_ack,
  output logic [DATA_WIDTH-1:0] text_rdata,
  output logic                  text_rvalid,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_dout,
  input  logic [DATA_WIDTH-1:0] sram_din,
  output logic                  sram_drive,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n
);

  localparam int unsigned WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(WAIT_CYCLES - 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RECOVER
  } state_t;

  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic [SCW-1:0] starve_cnt;
  logic           owner_text;
  logic           op_we;
  logic           pick_text;
  logic           pick_disp;

  // Display has priority unless text has been passed over STARVE_LIMIT times.
  always_comb begin
    pick_text = text_req && (!disp_req || (starve_cnt == STARVE_MAX));
    pick_disp = disp_req && !pick_text;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      starve_cnt  <= '0;
      owner_text  <= 1'b0;
      op_we       <= 1'b0;
      disp_ack    <= 1'b0;
      disp_rdata  <= '0;
      disp_rvalid <= 1'b0;
      text_ack    <= 1'b0;
      text_rdata  <= '0;
      text_rvalid <= 1'b0;
      sram_addr   <= '0;
      sram_dout   <= '0;
      sram_drive  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
    end else begin
      disp_ack    <= 1'b0;
      text_ack    <= 1'b0;
      disp_rvalid <= 1'b0;
      text_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          sram_drive <= 1'b0;
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          if (pick_text) begin
            state      <= ACCESS;
            wait_cnt   <= '0;
            owner_text <= 1'b1;
            op_we      <= text_we;
            sram_addr  <= text_addr;
            if (text_we) begin
              sram_dout <= text_wdata;
            end
            text_ack   <= 1'b1;
            starve_cnt <= '0;
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= text_we;
            sram_we_n  <= !text_we;
            sram_drive <= text_we;
          end else if (pick_disp) begin
            state      <= ACCESS;
            wait_cnt   <= '0;
            owner_text <= 1'b0;
            op_we      <= 1'b0;
            sram_addr  <= disp_addr;
            disp_ack   <= 1'b1;
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= 1'b0;
            sram_we_n  <= 1'b1;
            if (!text_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else if (!text_req) begin
            starve_cnt <= '0;
          end
        end
        ACCESS: begin
          if (wait_cnt == WAIT_LAST) begin
            // Strobes rise here; address, data and drive stay put through RECOVER.
            state     <= RECOVER;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            if (!op_we) begin
              if (owner_text) begin
                text_rdata  <= sram_din;
                text_rvalid <= 1'b1;
              end else begin
                disp_rdata  <= sram_din;
                disp_rvalid <= 1'b1;
              end
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RECOVER: begin
          state      <= IDLE;
          sram_drive <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          sram_drive <= 1'b0;
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule
